// File: rtl/axi_sram_responder.sv
// rtl/axi_sram_responder.sv - AXI3 single-beat SRAM responder with in-order, fixed-latency reads
// Optional feature macro: AXI_RESP_ERR_EN (SLVERR for addresses beyond the memory)
module axi_sram_responder #(
  parameter int MEM_AW   = 10,
  parameter int RD_DEPTH = 4,
  parameter int WR_DEPTH = 2,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int WORDS = 1 << MEM_AW;
  localparam int RPW   = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int RCW   = $clog2(RD_DEPTH + 1);
  localparam int BPW   = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;
  localparam int BCW   = $clog2(WR_DEPTH + 1);
  localparam int LW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  logic [31:0] mem [WORDS];

  logic [3:0]  rq_id   [RD_DEPTH];
  logic [31:0] rq_data [RD_DEPTH];
  logic [1:0]  rq_resp [RD_DEPTH];
  logic [RPW-1:0] rd_wptr, rd_rptr;
  logic [RCW-1:0] rd_count;
  logic [LW-1:0]  lat_cnt;

  logic [3:0] bq_id   [WR_DEPTH];
  logic [1:0] bq_resp [WR_DEPTH];
  logic [BPW-1:0] b_wptr, b_rptr;
  logic [BCW-1:0] b_count;

  logic              aw_held, w_held, aw_err_q;
  logic [3:0]        aw_id;
  logic [MEM_AW-1:0] aw_idx;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;

  logic [MEM_AW-1:0] ar_idx;
  logic              ar_err, aw_err;
  logic [31:0]       ar_data;
  logic [1:0]        ar_resp;
  logic              ar_fire, r_fire, aw_fire, w_fire, b_fire, commit;
  logic              unused_addr_bits;

  assign ar_idx = araddr[MEM_AW+1:2];

`ifdef AXI_RESP_ERR_EN
  assign ar_err = |araddr[31:MEM_AW+2];
  assign aw_err = |awaddr[31:MEM_AW+2];
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0], araddr[31:MEM_AW+2], awaddr[31:MEM_AW+2]};

  // Error flag doubles as the SLVERR encoding (2'b10); OKAY otherwise.
  assign ar_data = ar_err ? 32'h0 : mem[ar_idx];
  assign ar_resp = {ar_err, 1'b0};

  assign arready = resetn && (rd_count < RCW'(RD_DEPTH));
  assign rvalid  = (rd_count != '0) && (lat_cnt == '0);
  assign rlast   = rvalid;
  assign rid     = rvalid ? rq_id[rd_rptr]   : 4'h0;
  assign rdata   = rvalid ? rq_data[rd_rptr] : 32'h0;
  assign rresp   = rvalid ? rq_resp[rd_rptr] : 2'b00;

  assign awready = resetn && !aw_held;
  assign wready  = resetn && !w_held;
  assign bvalid  = (b_count != '0);
  assign bid     = bvalid ? bq_id[b_rptr]   : 4'h0;
  assign bresp   = bvalid ? bq_resp[b_rptr] : 2'b00;

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign b_fire  = bvalid && bready;
  assign commit  = aw_held && w_held && (b_count < BCW'(WR_DEPTH));

  // Read queue control; the latency counter restarts whenever a new entry becomes head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_wptr  <= '0;
      rd_rptr  <= '0;
      rd_count <= '0;
      lat_cnt  <= '0;
    end else begin
      if (ar_fire)
        rd_wptr <= (rd_wptr == RPW'(RD_DEPTH - 1)) ? '0 : rd_wptr + 1'b1;
      if (r_fire)
        rd_rptr <= (rd_rptr == RPW'(RD_DEPTH - 1)) ? '0 : rd_rptr + 1'b1;
      if (ar_fire && !r_fire)
        rd_count <= rd_count + 1'b1;
      else if (!ar_fire && r_fire)
        rd_count <= rd_count - 1'b1;
      if (r_fire ? ((rd_count > RCW'(1)) || ar_fire) : (ar_fire && (rd_count == '0)))
        lat_cnt <= LW'(LATENCY);
      else if (lat_cnt != '0)
        lat_cnt <= lat_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_err_q <= 1'b0;
      aw_id    <= '0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      b_wptr   <= '0;
      b_rptr   <= '0;
      b_count  <= '0;
    end else begin
      if (aw_fire) begin
        aw_held  <= 1'b1;
        aw_id    <= awid;
        aw_idx   <= awaddr[MEM_AW+1:2];
        aw_err_q <= aw_err;
      end else if (commit) begin
        aw_held <= 1'b0;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end else if (commit) begin
        w_held <= 1'b0;
      end
      if (commit)
        b_wptr <= (b_wptr == BPW'(WR_DEPTH - 1)) ? '0 : b_wptr + 1'b1;
      if (b_fire)
        b_rptr <= (b_rptr == BPW'(WR_DEPTH - 1)) ? '0 : b_rptr + 1'b1;
      if (commit && !b_fire)
        b_count <= b_count + 1'b1;
      else if (!commit && b_fire)
        b_count <= b_count - 1'b1;
    end
  end

  // Payload storage and memory are not reset; occupancy counters gate their visibility.
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      rq_id[rd_wptr]   <= arid;
      rq_data[rd_wptr] <= ar_data;
      rq_resp[rd_wptr] <= ar_resp;
    end
    if (commit) begin
      bq_id[b_wptr]   <= aw_id;
      bq_resp[b_wptr] <= {aw_err_q, 1'b0};
    end
    if (commit && !aw_err_q) begin
      for (int i = 0; i < 4; i++)
        if (w_strb[i])
          mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// tb/tb_axi_sram_responder.sv - directed and randomized checks of axi_sram_responder
// Honours AXI_RESP_ERR_EN when the design is built with it.
module tb_axi_sram_responder;
  localparam int LAT = 2;

`ifdef AXI_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] ref_mem [1024];

  always #5 clk = ~clk;

  axi_sram_responder #(.MEM_AW(10), .RD_DEPTH(4), .WR_DEPTH(2), .LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return ERR_EN && ((a >> 12) != 32'h0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    if (oor(a)) begin d = 32'h0; r = 2'b10; end
    else begin d = ref_mem[widx(a)]; r = 2'b00; end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    if (oor(a)) r = 2'b10;
    else begin
      r = 2'b00;
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a | 32'h1000;
    return a;
  endfunction

  task automatic collect_r(input string tag, input logic [3:0] eid, input logic [31:0] ed,
                           input logic [1:0] er, input bit rnd);
    bit got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && rready) begin
        chk({tag, "_rid"}, 32'(rid), 32'(eid));
        chk({tag, "_rdata"}, rdata, ed);
        chk({tag, "_rresp"}, 32'(rresp), 32'(er));
        chk({tag, "_rlast"}, 32'(rlast), 32'd1);
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    rready = 1'b0;
    chk({tag, "_r_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic collect_b(input string tag, input logic [3:0] eid, input logic [1:0] er,
                           input bit rnd);
    bit got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid && bready) begin
        chk({tag, "_bid"}, 32'(bid), 32'(eid));
        chk({tag, "_bresp"}, 32'(bresp), 32'(er));
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    bready = 1'b0;
    chk({tag, "_b_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic issue_ar(input string tag, input logic [3:0] id, input logic [31:0] a);
    bit got = 1'b0;
    arid = id; araddr = a; arvalid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (arready) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    arvalid = 1'b0;
    chk({tag, "_ar_timeout"}, 32'(got), 32'd1);
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; the other follows after gap cycles.
  task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int order,
                          input int gap, input bit rnd);
    bit a_done = 1'b0, w_done = 1'b0, a_hs, w_hs;
    logic [1:0] er;
    awid = id; awaddr = a; wdata = d; wstrb = s;
    for (int c = 0; c < 64 && !(a_done && w_done); c++) begin
      if (!a_done) awvalid = (order != 2) || (c >= gap);
      if (!w_done) wvalid = (order != 1) || (c >= gap);
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      tick();
      if (a_hs) begin a_done = 1'b1; awvalid = 1'b0; end
      if (w_hs) begin w_done = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    chk({tag, "_aw_w_accept"}, {30'h0, a_done, w_done}, 32'd3);
    model_write(a, d, s, er);
    collect_b(tag, id, er, rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, old_d, new_d;
    logic [1:0]  r;
    logic [31:0] qd [5];
    logic [1:0]  qr [5];
    logic [3:0]  ids [4];
    logic [31:0] ed [4];
    logic [1:0]  er [4];
    int k;

    #1;
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rid_rdata_rresp", {rid, rdata[25:0], rresp}, 0);
    chk("rst_bid_bresp", {26'h0, bid, bresp}, 0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Reset pulse with a read in flight: its response must never appear.
    arid = 4'd3; araddr = 32'h10; arvalid = 1'b1;
    chk("rstmid_arready", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rstmid_arready_in_reset", 32'(arready), 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rstmid_arready_after", 32'(arready), 1);
    chk("rstmid_rvalid_after", 32'(rvalid), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("rstmid_rvalid_late", 32'(rvalid), 0);

    for (int w = 0; w < 16; w++)
      do_write("init", 4'(w), 32'(w * 4), $urandom, 4'hF, int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), 1'b1);

    // Write then read with exact cycle timing.
    awid = 4'd1; awaddr = 32'h40; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    chk("wr_ready_both", {30'h0, awready, wready}, 32'd3);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_awready_held", 32'(awready), 0);
    chk("wr_bvalid_commit_cycle", 32'(bvalid), 0);
    tick();
    chk("wr_bvalid", 32'(bvalid), 1);
    chk("wr_bid", 32'(bid), 1);
    chk("wr_bresp", 32'(bresp), 0);
    chk("wr_awready_back", 32'(awready), 1);
    tick();
    bready = 1'b0;
    chk("wr_bvalid_popped", 32'(bvalid), 0);
    model_write(32'h40, 32'hDEADBEEF, 4'hF, r);

    arid = 4'd2; araddr = 32'h40; arvalid = 1'b1; rready = 1'b1;
    chk("rd_arready", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      chk("rd_latency_rvalid_low", 32'(rvalid), 0);
      tick();
    end
    chk("rd_rvalid", 32'(rvalid), 1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_rid", 32'(rid), 2);
    chk("rd_rlast", 32'(rlast), 1);
    chk("rd_rresp", 32'(rresp), 0);
    tick();
    rready = 1'b0;
    chk("rd_rvalid_popped", 32'(rvalid), 0);

    do_write("strb", 4'd3, 32'h40, 32'h11223344, 4'b0101, 0, 0, 1'b0);
    issue_ar("strb", 4'd4, 32'h40);
    collect_r("strb", 4'd4, 32'hDE22BE44, 2'b00, 1'b0);

    // Read queue full: four accepted, fifth waits for the first pop.
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arid = 4'(i); araddr = 32'(i * 4); arvalid = 1'b1;
      chk("qfull_arready", 32'(arready), 1);
      model_read(araddr, qd[i], qr[i]);
      tick();
    end
    arid = 4'd4; araddr = 32'h40;
    model_read(araddr, qd[4], qr[4]);
    chk("qfull_5th_arready", 32'(arready), 0);
    tick();
    chk("qfull_still_full", 32'(arready), 0);
    chk("qfull_head_rvalid", 32'(rvalid), 1);
    chk("qfull_head_rid", 32'(rid), 0);
    chk("qfull_head_rdata", rdata, qd[0]);
    rready = 1'b1;
    tick();
    chk("qfull_arready_after_pop", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    rready = 1'b0;
    for (int i = 1; i < 5; i++) collect_r("qfull", 4'(i), qd[i], qr[i], 1'b0);

    // W three cycles ahead of AW.
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    chk("wfirst_wready", 32'(wready), 1);
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready_drop", 32'(wready), 0);
    tick(); tick();
    chk("wfirst_no_commit", 32'(bvalid), 0);
    chk("wfirst_wready_still_low", 32'(wready), 0);
    awid = 4'd5; awaddr = 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid_commit_cycle", 32'(bvalid), 0);
    tick();
    chk("wfirst_bvalid", 32'(bvalid), 1);
    chk("wfirst_bid", 32'(bid), 5);
    chk("wfirst_wready_back", 32'(wready), 1);
    model_write(32'h8, 32'hA5A5A5A5, 4'hF, r);
    collect_b("wfirst", 4'd5, 2'b00, 1'b0);
    chk("wfirst_single_commit", 32'(bvalid), 0);
    issue_ar("wfirst", 4'd6, 32'h8);
    collect_r("wfirst", 4'd6, 32'hA5A5A5A5, 2'b00, 1'b0);

    // Read-after-write hazard: old data in the commit cycle, new data one cycle later.
    old_d = ref_mem[5];
    new_d = $urandom;
    wdata = new_d; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    awid = 4'd7; awaddr = 32'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    arid = 4'd8; araddr = 32'h14; arvalid = 1'b1;
    chk("haz_arready0", 32'(arready), 1);
    tick();
    arid = 4'd9;
    chk("haz_arready1", 32'(arready), 1);
    tick();
    arvalid = 1'b0;
    model_write(32'h14, new_d, 4'hF, r);
    collect_b("haz", 4'd7, 2'b00, 1'b0);
    collect_r("haz_old", 4'd8, old_d, 2'b00, 1'b0);
    collect_r("haz_new", 4'd9, new_d, 2'b00, 1'b0);

    // Address above the memory: SLVERR with the feature, word-0 alias without.
    model_read(32'h1000, d, r);
    issue_ar("oor", 4'hA, 32'h1000);
    collect_r("oor", 4'hA, d, r, 1'b0);
    do_write("oor_wr", 4'hB, 32'h1000, $urandom, 4'hF, 0, 0, 1'b0);
    model_read(32'h0, d, r);
    issue_ar("oor_chk", 4'hC, 32'h0);
    collect_r("oor_chk", 4'hC, d, r, 1'b0);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write("rnd_wr", 4'($urandom_range(0, 15)), rand_addr(), $urandom,
                 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), 1'b1);
      end else begin
        k = int'($urandom_range(1, 4));
        for (int j = 0; j < k; j++) begin
          ids[j] = 4'($urandom_range(0, 15));
          d = rand_addr();
          model_read(d, ed[j], er[j]);
          issue_ar("rnd_rd", ids[j], d);
        end
        for (int j = 0; j < k; j++) collect_r("rnd_rd", ids[j], ed[j], er[j], 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
